dcache_refill_buffer: RTL and testbench
=======================================

Name: dcache_refill_buffer

Overview:
- Sits between the AXI read channel and the data-cache line store.
- Issues one 8-beat WRAP read burst per miss and assembles the 32-bit beats into a 256-bit line.
- The assembled line goes to the cache data RAM and to the word-select stage, which picks a word by its 3-bit offset.
- Returns the critical (missed) word one cycle after it arrives, so the pipeline can restart early.

Parameters:
- LINE_WORDS, 8, words per line. Fixed at 8; the offset is 3 bits.
- DATA_W, 32, beat and word width.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  miss refill request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  miss byte address
- ar_valid  out  1  AXI read address valid
- ar_ready  in  1  AXI read address ready
- ar_addr  out  ADDR_W  {req_addr[31:2],2'b00}
- ar_len  out  4  constant 4'd7
- ar_size  out  3  constant 3'b010
- ar_burst  out  2  constant 2'b10 (WRAP)
- r_valid  in  1  read data valid
- r_ready  out  1  high only in DATA
- r_data  in  DATA_W  beat data
- r_last  in  1  last beat
- crit_valid  out  1  one-cycle pulse: critical word available
- crit_data  out  DATA_W  critical word
- line_valid  out  1  assembled line ready
- line_data  out  LINE_WORDS*DATA_W  word i at bits [32i+31:32i]
- line_addr  out  ADDR_W  {addr[31:5],5'b0}
- line_ack  in  1  consumer accepted the line
- burst_err  out  1  sticky r_last/beat-count mismatch flag

Behaviour:
- Reset: synchronous. On reset:
  - state goes to IDLE;
  - ar_valid, r_ready, crit_valid, line_valid and burst_err go to 0;
  - line_data, line_addr and crit_data go to 0;
  - the beat counter goes to 0.
- Reset mid-burst abandons the transaction with no completion. The interconnect is reset at the same time.
- State IDLE:
  - req_ready=1.
  - req_valid latches addr, start offset off=req_addr[4:2], wptr=off and cnt=0, then moves to ADDR next cycle.
  - Any previous line_data is not cleared.
- State ADDR:
  - ar_valid=1 with ar_addr held stable.
  - The handshake completes when ar_valid&ar_ready; the next state is DATA.
  - Zero-wait ar_ready completes in one cycle.
- State DATA:
  - r_ready=1.
  - On each r_valid&r_ready beat: line word[wptr] <= r_data, wptr <= wptr+1 mod 8 (wraps 7->0), cnt <= cnt+1.
  - On the beat with cnt==0 (critical word), the cycle after acceptance has crit_valid=1 and crit_data=r_data for exactly one cycle.
  - On the beat with cnt==7, the next state is DONE.
  - If r_last != (cnt==7) on any accepted beat, set burst_err (sticky until reset).
  - The beat count still governs completion; r_last is not used to terminate.
  - Gaps (r_valid=0) just stall; no timeout.
- State DONE:
  - line_valid=1 and line_addr stable.
  - line_data is valid for all 8 words.
  - line_ack returns to IDLE next cycle (line_valid drops).
  - line_ack in the same cycle DONE is entered is honoured: one-cycle line_valid pulse.
- Latency, zero-wait AXI:
  - req accepted at cycle T, ar handshake at T+1.
  - First beat at T+2 or later; crit_valid the cycle after the first beat.
  - line_valid the cycle after the 8th beat.
- A new req_valid outside IDLE is ignored (req_ready=0). Back-to-back refills require line_ack.
- line_data is written only through beat writes. Words not yet written in the current burst keep stale values; consumers read only with line_valid.
- No outstanding-transaction support: one burst in flight.

Test Plan:
- Aligned miss: req_addr=0x0000_1000, beats 0xA0..0xA7 zero-wait, r_last on 8th.
  - ar_addr=0x1000, ar_len=7, ar_burst=2'b10.
  - crit_data=0xA0.
  - line words 0..7=0xA0..0xA7, line_addr=0x1000.
- Wrapped miss: req_addr=0x0000_2014 (off=5), beats B0..B7.
  - crit_data=B0.
  - word5=B0, word6=B1, word7=B2, word0=B3 … word4=B7.
- Stalled stream: r_valid toggling 1,0,0,1, ar_ready delayed 3 cycles.
  - ar_addr stable while ar_valid.
  - Exactly 8 writes; line_valid only after the 8th accepted beat.
  - crit_valid is exactly one pulse.
- Early r_last on beat 3.
  - burst_err=1 and stays 1.
  - FSM still waits for 8 beats, then DONE.
- rst asserted during beat 4.
  - The next cycle has ar_valid=r_ready=line_valid=0 and req_ready=1.
  - A fresh request completes normally.
- DONE hold: line_ack held low 10 cycles.
  - line_valid stays 1 and req_ready stays 0.
  - After ack, next-cycle req_ready=1 and line_valid=0.

Source files
------------

// File: rtl/dcache_refill_buffer.sv
// dcache_refill_buffer
//   Refills one data-cache line per miss. A request latches the miss address,
//   one 8-beat AXI WRAP read burst is issued, and the 32-bit beats are written
//   into a 256-bit line starting at the missed word. The missed (critical) word
//   is forwarded one cycle after it arrives so the pipeline can restart early.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready miss request handshake (ready only while idle)
//   req_addr        miss byte address
//   ar_*            AXI read address channel (WRAP, 8 x 32-bit beats)
//   r_*             AXI read data channel (ready only while collecting beats)
//   crit_valid/data one-cycle pulse carrying the critical word
//   line_valid/data assembled line, word i at bits [32i+31:32i]
//   line_addr       line-aligned address of the assembled line
//   line_ack        consumer accepted the line
//   burst_err       sticky flag: r_last disagreed with the beat count
module dcache_refill_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         ar_valid,
    input  logic                         ar_ready,
    output logic [ADDR_W-1:0]            ar_addr,
    output logic [3:0]                   ar_len,
    output logic [2:0]                   ar_size,
    output logic [1:0]                   ar_burst,
    input  logic                         r_valid,
    output logic                         r_ready,
    input  logic [DATA_W-1:0]            r_data,
    input  logic                         r_last,
    output logic                         crit_valid,
    output logic [DATA_W-1:0]            crit_data,
    output logic                         line_valid,
    output logic [LINE_WORDS*DATA_W-1:0] line_data,
    output logic [ADDR_W-1:0]            line_addr,
    input  logic                         line_ack,
    output logic                         burst_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t state_q, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        wptr_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] words_q [LINE_WORDS];
    logic              beat;
    logic              last_beat;

    assign beat      = r_valid & r_ready;
    assign last_beat = (cnt_q == 3'd7);

    assign ar_len   = 4'd7;
    assign ar_size  = 3'b010;
    assign ar_burst = 2'b10;

    // Byte and line alignment are applied by masking so the full latched
    // address stays in one register.
    assign ar_addr   = addr_q & ~ADDR_W'(3);
    assign line_addr = addr_q & ~ADDR_W'(31);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; completion is governed by the beat count, not r_last
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: if (req_valid)           state_n = S_ADDR;
            S_ADDR: if (ar_ready)            state_n = S_DATA;
            S_DATA: if (beat && last_beat)   state_n = S_DONE;
            S_DONE: if (line_ack)            state_n = S_IDLE;
            default:                         state_n = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready  = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        line_valid = 1'b0;
        case (state_q)
            S_IDLE:  req_ready  = 1'b1;
            S_ADDR:  ar_valid   = 1'b1;
            S_DATA:  r_ready    = 1'b1;
            S_DONE:  line_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address latch, wrap pointer, beat counter and line words
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            burst_err  <= 1'b0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            crit_valid <= 1'b0;
            if (state_q == S_IDLE && req_valid) begin
                addr_q <= req_addr;
                wptr_q <= req_addr[4:2];
                cnt_q  <= '0;
            end
            if (beat) begin
                words_q[wptr_q] <= r_data;
                wptr_q          <= wptr_q + 3'd1;
                cnt_q           <= cnt_q + 3'd1;
                if (cnt_q == 3'd0) begin
                    crit_valid <= 1'b1;
                    crit_data  <= r_data;
                end
                if (r_last != last_beat) begin
                    burst_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        line_data = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            line_data[i*DATA_W +: DATA_W] = words_q[i];
        end
    end

endmodule

// File: tb/tb_dcache_refill_buffer.sv
module tb_dcache_refill_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  ar_addr;
    logic [3:0]   ar_len;
    logic [2:0]   ar_size;
    logic [1:0]   ar_burst;
    logic         r_valid;
    logic         r_ready;
    logic [31:0]  r_data;
    logic         r_last;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_valid;
    logic [255:0] line_data;
    logic [31:0]  line_addr;
    logic         line_ack;
    logic         burst_err;

    dcache_refill_buffer #(
        .LINE_WORDS(8),
        .DATA_W(32),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .ar_valid(ar_valid),
        .ar_ready(ar_ready),
        .ar_addr(ar_addr),
        .ar_len(ar_len),
        .ar_size(ar_size),
        .ar_burst(ar_burst),
        .r_valid(r_valid),
        .r_ready(r_ready),
        .r_data(r_data),
        .r_last(r_last),
        .crit_valid(crit_valid),
        .crit_data(crit_data),
        .line_valid(line_valid),
        .line_data(line_data),
        .line_addr(line_addr),
        .line_ack(line_ack),
        .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int crit_pulses = 0;

    // Reference model: contents of the line store and the sticky error flag
    logic [31:0] m_words [8];
    bit          m_err;

    always @(negedge clk) begin
        if (crit_valid === 1'b1) crit_pulses++;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] model_line();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_words[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_words[i] = '0;
        m_err = 1'b0;
    endtask

    // Checks that follow acceptance of beat k (sampled on the next negedge)
    task automatic post_beat(input int k, input logic [31:0] crit_exp);
        if (k == 0) begin
            chk("crit_valid", {255'b0, crit_valid}, 256'd1);
            chk("crit_data", {224'b0, crit_data}, {224'b0, crit_exp});
        end
        if (k < 7) chk("line_valid_early", {255'b0, line_valid}, 256'd0);
    endtask

    // One complete refill; called at posedge+#1 with the DUT idle.
    // gap_mode: 0 none, 1 pattern 1,0,0,1 (two idle cycles before odd beats), 2 random
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] base,
                             input int ar_wait, input int gap_mode, input int last_at,
                             input int hold, input bit noise, input bit rnd_data,
                             input logic [31:0] exp_ar, input logic [31:0] exp_la,
                             input bit exp_err);
        logic [31:0] bt [8];
        int          pend;
        int          g;
        int          crit_before;
        int          off;

        for (int k = 0; k < 8; k++) bt[k] = rnd_data ? $urandom : base + k;
        off = int'(addr[4:2]);
        crit_before = crit_pulses;

        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        chk("req_ready_idle", {255'b0, req_ready}, 256'd1);
        @(posedge clk); #1;
        req_valid = noise ? 1'($urandom) : 1'b0;
        req_addr  = $urandom;
        ar_ready  = (ar_wait == 0);

        for (int w = 0; w <= ar_wait; w++) begin
            @(negedge clk);
            chk("ar_valid", {255'b0, ar_valid}, 256'd1);
            chk("ar_addr", {224'b0, ar_addr}, {224'b0, exp_ar});
            if (w == 0) begin
                chk("ar_len", {252'b0, ar_len}, 256'd7);
                chk("ar_size", {253'b0, ar_size}, 256'd2);
                chk("ar_burst", {254'b0, ar_burst}, 256'd2);
                chk("req_ready_busy", {255'b0, req_ready}, 256'd0);
            end
            @(posedge clk); #1;
            ar_ready = (w + 1 == ar_wait);
        end
        ar_ready = 1'b0;

        pend = -1;
        for (int k = 0; k < 8; k++) begin
            if (gap_mode == 1) g = (k % 2 == 1) ? 2 : 0;
            else if (gap_mode == 2) g = $urandom_range(0, 2);
            else g = 0;
            repeat (g) begin
                r_valid = 1'b0;
                @(negedge clk);
                if (pend >= 0) begin post_beat(pend, bt[0]); pend = -1; end
                @(posedge clk); #1;
            end
            r_valid = 1'b1;
            r_data  = bt[k];
            r_last  = (k == last_at);
            @(negedge clk);
            if (pend >= 0) begin post_beat(pend, bt[0]); pend = -1; end
            if (k == 0) chk("r_ready", {255'b0, r_ready}, 256'd1);
            @(posedge clk); #1;
            if (noise) req_addr = $urandom;
            m_words[(off + k) % 8] = bt[k];
            pend = k;
        end
        r_valid  = 1'b0;
        r_last   = 1'b0;
        line_ack = (hold == 0);

        @(negedge clk);
        chk("line_valid", {255'b0, line_valid}, 256'd1);
        chk("line_addr", {224'b0, line_addr}, {224'b0, exp_la});
        chk("line_data", line_data, model_line());
        chk("burst_err", {255'b0, burst_err}, {255'b0, exp_err});
        chk("req_ready_done", {255'b0, req_ready}, 256'd0);
        m_err = exp_err;
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            line_ack = (h == hold);
            @(negedge clk);
            chk("line_valid_hold", {255'b0, line_valid}, 256'd1);
            chk("req_ready_hold", {255'b0, req_ready}, 256'd0);
        end
        @(posedge clk); #1;
        line_ack  = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("line_valid_after_ack", {255'b0, line_valid}, 256'd0);
        chk("req_ready_after_ack", {255'b0, req_ready}, 256'd1);
        chk("crit_pulse_count", 256'(crit_pulses - crit_before), 256'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          ar_wait;
        int          gap;
        int          last_at;
        int          hold;
        bit          noise;
        logic [31:0] exp_ar;
        logic [31:0] exp_la;
        bit          exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] a;
        int          la;

        tbl[0] = '{32'h0000_1000, 32'hA0, 0, 0, 7, 0,  1'b0, 32'h0000_1000, 32'h0000_1000, 1'b0};
        tbl[1] = '{32'h0000_2014, 32'hB0, 0, 0, 7, 0,  1'b1, 32'h0000_2014, 32'h0000_2000, 1'b0};
        tbl[2] = '{32'h0000_3008, 32'hC0, 3, 1, 7, 1,  1'b1, 32'h0000_3008, 32'h0000_3000, 1'b0};
        tbl[3] = '{32'h0000_401F, 32'hD0, 1, 0, 7, 10, 1'b1, 32'h0000_401C, 32'h0000_4000, 1'b0};
        tbl[4] = '{32'h0000_5004, 32'hE0, 0, 0, 3, 2,  1'b0, 32'h0000_5004, 32'h0000_5000, 1'b1};
        tbl[5] = '{32'h0000_6000, 32'hF0, 0, 2, 7, 0,  1'b1, 32'h0000_6000, 32'h0000_6000, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; ar_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_last = 1'b0; line_ack = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", {255'b0, req_ready}, 256'd1);
        chk("rst_ar_valid", {255'b0, ar_valid}, 256'd0);
        chk("rst_r_ready", {255'b0, r_ready}, 256'd0);
        chk("rst_line_valid", {255'b0, line_valid}, 256'd0);
        chk("rst_crit_valid", {255'b0, crit_valid}, 256'd0);
        chk("rst_burst_err", {255'b0, burst_err}, 256'd0);
        chk("rst_line_data", line_data, 256'd0);
        chk("rst_line_addr", {224'b0, line_addr}, 256'd0);
        chk("rst_crit_data", {224'b0, crit_data}, 256'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_refill(tbl[i].addr, tbl[i].base, tbl[i].ar_wait, tbl[i].gap, tbl[i].last_at,
                      tbl[i].hold, tbl[i].noise, 1'b0, tbl[i].exp_ar, tbl[i].exp_la,
                      tbl[i].exp_err);
        end

        // Reset while beat 4 is on the bus abandons the burst
        req_valid = 1'b1;
        req_addr  = 32'h0000_7008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ar_ready  = 1'b1;
        @(posedge clk); #1;
        ar_ready  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1;
            r_data  = 32'h7700 + k;
            @(posedge clk); #1;
        end
        r_valid = 1'b1;
        r_data  = 32'h7704;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        r_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk("mid_rst_ar_valid", {255'b0, ar_valid}, 256'd0);
        chk("mid_rst_r_ready", {255'b0, r_ready}, 256'd0);
        chk("mid_rst_line_valid", {255'b0, line_valid}, 256'd0);
        chk("mid_rst_req_ready", {255'b0, req_ready}, 256'd1);
        chk("mid_rst_burst_err", {255'b0, burst_err}, 256'd0);
        chk("mid_rst_line_data", line_data, 256'd0);
        @(posedge clk); #1;
        do_refill(32'h0000_8010, 32'h80, 0, 0, 7, 0, 1'b0, 1'b0,
                  32'h0000_8010, 32'h0000_8000, 1'b0);

        // Randomized refills against the model
        for (int n = 0; n < 25; n++) begin
            a  = $urandom;
            la = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : 7;
            do_refill(a, 32'h0, $urandom_range(0, 3), 2, la, $urandom_range(0, 3),
                      1'b1, 1'b1, a & ~32'd3, a & ~32'd31, m_err | (la != 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
